// File: rtl/direct_mapped_cache_n_words.sv
// Direct-mapped, write-through, write-allocate cache with one data word per line.
// Latency: a read hit returns data on douta one cycle later. A miss goes to RAM through
// fetch/fetch_ack. A write completes locally and then goes to RAM through flush/flush_ack.
// Backpressure: while a flush or a fetch is outstanding the block ignores wea and stalls in
// that state until the matching ack is sampled high.
// Ports:
//   clka, rsta          clock, asynchronous active-high reset
//   wea, addra, dina    CPU request (dina also carries RAM fill data while fetch_ack is high)
//   fetch_ack,flush_ack RAM handshake acknowledgements
//   douta, flush, fetch registered outputs
//   hit                 combinational hit indication for the current addra
module direct_mapped_cache_n_words #(
  parameter int N_WORDS    = 1024,
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clka,
  input  logic                  rsta,
  input  logic                  wea,
  input  logic [ADDR_WIDTH-1:0] addra,
  input  logic [DATA_WIDTH-1:0] dina,
  input  logic                  fetch_ack,
  input  logic                  flush_ack,
  output logic [DATA_WIDTH-1:0] douta,
  output logic                  flush,
  output logic                  fetch,
  output logic                  hit
);

  localparam int IDX_W = $clog2(N_WORDS);
  localparam int TAG_W = ADDR_WIDTH - IDX_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FLUSH = 2'd1,
    S_FETCH = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] douta_q, douta_d;
  logic                  flush_q, flush_d;
  logic                  fetch_q, fetch_d;
  logic [IDX_W-1:0]      fill_idx_q, fill_idx_d;
  logic [TAG_W-1:0]      fill_tag_q, fill_tag_d;
  logic [N_WORDS-1:0]    valid_q;

  // The line storage has no reset. Only the valid bits are cleared.
  logic [DATA_WIDTH-1:0] data_mem [N_WORDS];
  logic [TAG_W-1:0]      tag_mem  [N_WORDS];

  logic [IDX_W-1:0]      idx;
  logic [TAG_W-1:0]      tag;
  logic                  line_match;

  // A CPU write and a RAM fill share one line-write port.
  logic                  wr_en;
  logic [IDX_W-1:0]      wr_idx;
  logic [TAG_W-1:0]      wr_tag;
  logic [DATA_WIDTH-1:0] wr_dat;

  assign idx        = addra[IDX_W-1:0];
  assign tag        = addra[ADDR_WIDTH-1:IDX_W];
  assign line_match = valid_q[idx] && (tag_mem[idx] == tag);

  assign hit   = (state_q == S_IDLE) && line_match;
  assign douta = douta_q;
  assign flush = flush_q;
  assign fetch = fetch_q;

  always_comb begin
    state_d    = state_q;
    douta_d    = douta_q;
    flush_d    = flush_q;
    fetch_d    = fetch_q;
    fill_idx_d = fill_idx_q;
    fill_tag_d = fill_tag_q;
    wr_en      = 1'b0;
    wr_idx     = idx;
    wr_tag     = tag;
    wr_dat     = dina;

    case (state_q)
      S_IDLE: begin
        if (wea) begin
          // RAM always holds current data, so the old occupant is dropped without a writeback.
          wr_en   = 1'b1;
          douta_d = dina;
          flush_d = 1'b1;
          state_d = S_FLUSH;
        end else if (line_match) begin
          douta_d = data_mem[idx];
        end else begin
          // Capture the miss address so later addra changes cannot redirect the fill.
          fill_idx_d = idx;
          fill_tag_d = tag;
          fetch_d    = 1'b1;
          state_d    = S_FETCH;
        end
      end

      S_FLUSH: begin
        if (flush_ack) begin
          flush_d = 1'b0;
          state_d = S_IDLE;
        end
      end

      S_FETCH: begin
        if (fetch_ack) begin
          wr_en   = 1'b1;
          wr_idx  = fill_idx_q;
          wr_tag  = fill_tag_q;
          douta_d = dina;
          fetch_d = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        flush_d = 1'b0;
        fetch_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      state_q    <= S_IDLE;
      douta_q    <= '0;
      flush_q    <= 1'b0;
      fetch_q    <= 1'b0;
      fill_idx_q <= '0;
      fill_tag_q <= '0;
      valid_q    <= '0;
    end else begin
      state_q    <= state_d;
      douta_q    <= douta_d;
      flush_q    <= flush_d;
      fetch_q    <= fetch_d;
      fill_idx_q <= fill_idx_d;
      fill_tag_q <= fill_tag_d;
      if (wr_en) begin
        valid_q[wr_idx] <= 1'b1;
      end
    end
  end

  // Writes that land here while the block is in reset are harmless.
  // The valid bits stay cleared, so those lines can never produce a hit.
  always_ff @(posedge clka) begin
    if (wr_en) begin
      data_mem[wr_idx] <= wr_dat;
      tag_mem[wr_idx]  <= wr_tag;
    end
  end

endmodule

// File: tb/tb_direct_mapped_cache_n_words.sv
// Scoreboard bench for direct_mapped_cache_n_words.
// Each driven cycle pushes the expected outputs. The negedge monitor pops them and compares.
// The reference model is a tag/data map per line, indexed by address modulo 1024.
module tb_direct_mapped_cache_n_words;

  localparam int N = 1024;

  logic        clka;
  logic        rsta;
  logic        wea;
  logic [11:0] addra;
  logic [31:0] dina;
  logic        fetch_ack;
  logic        flush_ack;
  logic [31:0] douta;
  logic        flush;
  logic        fetch;
  logic        hit;

  direct_mapped_cache_n_words #(
    .N_WORDS(1024), .ADDR_WIDTH(12), .DATA_WIDTH(32)
  ) dut (
    .clka(clka), .rsta(rsta), .wea(wea), .addra(addra), .dina(dina),
    .fetch_ack(fetch_ack), .flush_ack(flush_ack),
    .douta(douta), .flush(flush), .fetch(fetch), .hit(hit)
  );

  // Start high so the first negedge falls before the first posedge.
  initial clka = 1'b1;
  always #5 clka = ~clka;

  typedef struct {
    string       name;
    logic [31:0] d;
    logic        h;
    logic        fl;
    logic        fe;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  // Reference model: contents of each line and the last value presented on douta.
  bit          ref_v   [N];
  int unsigned ref_tag [N];
  logic [31:0] ref_dat [N];
  logic [31:0] ref_douta;

  function automatic bit ref_hit(int unsigned a);
    return ref_v[a % N] && (ref_tag[a % N] == a / N);
  endfunction

  task automatic chk(string nm, string fld, logic [31:0] act, logic [31:0] req);
    n_assert++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s.%s: got %0d, required %0d (t=%0t)", nm, fld, act, req, $time);
    end
  endtask

  // Monitor
  always @(negedge clka) begin
    exp_t e;
    n_assert++;
    if (flush === 1'b1 && fetch === 1'b1) begin
      n_fail++;
      $display("FAIL exclusive: flush and fetch both high (t=%0t)", $time);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.name, "douta", douta, e.d);
      chk(e.name, "hit",   {31'd0, hit},   {31'd0, e.h});
      chk(e.name, "flush", {31'd0, flush}, {31'd0, e.fl});
      chk(e.name, "fetch", {31'd0, fetch}, {31'd0, e.fe});
    end
  end

  // Push this cycle's expectation, then advance to just after the next rising edge.
  task automatic step(string nm, logic [31:0] d, logic h, logic fl, logic fe);
    exp_t e;
    e.name = nm; e.d = d; e.h = h; e.fl = fl; e.fe = fe;
    sb.push_back(e);
    @(posedge clka);
    #1;
  endtask

  task automatic do_write(int unsigned a, logic [31:0] data, int delay, bit noise);
    addra = a[11:0]; dina = data; wea = 1'b1; fetch_ack = 1'b0; flush_ack = 1'b0;
    step("wr_issue", ref_douta, ref_hit(a), 1'b0, 1'b0);
    ref_v[a % N] = 1'b1; ref_tag[a % N] = a / N; ref_dat[a % N] = data; ref_douta = data;
    wea = 1'b0;
    for (int i = 0; i < delay; i++) begin
      dina = $urandom;
      if (noise) begin
        wea = 1'($urandom_range(0, 1)); fetch_ack = 1'($urandom_range(0, 1));
        addra = 12'($urandom);
      end
      step("wr_flush", ref_douta, 1'b0, 1'b1, 1'b0);
    end
    flush_ack = 1'b1;
    if (noise) wea = 1'($urandom_range(0, 1));
    step("wr_ack", ref_douta, 1'b0, 1'b1, 1'b0);
    flush_ack = 1'b0; fetch_ack = 1'b0; wea = 1'b0; addra = a[11:0];
  endtask

  task automatic do_read(int unsigned a, logic [31:0] fill, int delay, bit noise);
    bit h;
    addra = a[11:0]; wea = 1'b0; dina = $urandom;
    // Acks in IDLE must be ignored.
    fetch_ack = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    flush_ack = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    h = ref_hit(a);
    step("rd_issue", ref_douta, h, 1'b0, 1'b0);
    if (h) begin
      ref_douta = ref_dat[a % N];
    end else begin
      for (int i = 0; i < delay; i++) begin
        fetch_ack = 1'b0; dina = $urandom;
        if (noise) begin
          wea = 1'($urandom_range(0, 1)); flush_ack = 1'($urandom_range(0, 1));
          addra = 12'($urandom);
        end else begin
          flush_ack = 1'b0;
        end
        step("rd_fetch", ref_douta, 1'b0, 1'b0, 1'b1);
      end
      fetch_ack = 1'b1; dina = fill;
      flush_ack = 1'b0;
      if (noise) wea = 1'($urandom_range(0, 1));
      step("rd_ack", ref_douta, 1'b0, 1'b0, 1'b1);
      ref_v[a % N] = 1'b1; ref_tag[a % N] = a / N; ref_dat[a % N] = fill; ref_douta = fill;
    end
    fetch_ack = 1'b0; flush_ack = 1'b0; wea = 1'b0; addra = a[11:0];
  endtask

  // Start a miss, then assert reset in the middle of the FETCH wait.
  task automatic reset_mid_fetch(int unsigned a);
    addra = a[11:0]; wea = 1'b0; fetch_ack = 1'b0; flush_ack = 1'b0;
    step("rst_issue", ref_douta, ref_hit(a), 1'b0, 1'b0);
    step("rst_fetch", ref_douta, 1'b0, 1'b0, 1'b1);
    rsta = 1'b1;
    for (int i = 0; i < N; i++) ref_v[i] = 1'b0;
    ref_douta = '0;
    // Compared before the next clock edge: the reset must take effect asynchronously.
    step("rst_async", 32'd0, 1'b0, 1'b0, 1'b0);
    fetch_ack = 1'b1; dina = $urandom;
    step("rst_hold", 32'd0, 1'b0, 1'b0, 1'b0);
    fetch_ack = 1'b0;
    rsta = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int unsigned idx_pool [4];
    int unsigned a;
    idx_pool[0] = 0; idx_pool[1] = 1; idx_pool[2] = 5; idx_pool[3] = 1023;

    for (int i = 0; i < N; i++) begin
      ref_v[i] = 1'b0; ref_tag[i] = 0; ref_dat[i] = '0;
    end
    ref_douta = '0;
    rsta = 1'b1; wea = 1'b0; addra = '0; dina = '0; fetch_ack = 1'b0; flush_ack = 1'b0;
    step("reset", 32'd0, 1'b0, 1'b0, 1'b0);
    step("reset", 32'd0, 1'b0, 1'b0, 1'b0);
    rsta = 1'b0;

    do_write(0, 32'd2123000123, 10, 1'b0);
    do_read(0, 32'd0, 0, 1'b0);
    do_read(1000, 32'd1002003009, 3, 1'b0);
    do_read(1000, 32'd0, 0, 1'b0);
    do_read(0, 32'd0, 0, 1'b0);
    do_write(1024, 32'd998, 2, 1'b0);
    do_read(1024, 32'd0, 0, 1'b0);
    do_read(0, 32'd55555, 1, 1'b0);
    reset_mid_fetch(3000);
    do_read(1000, 32'd4242, 2, 1'b0);
    do_write(5, 32'd777, 4, 1'b1);
    do_read(5, 32'd0, 0, 1'b0);
    do_read(1000, 32'd0, 0, 1'b0);

    for (int n = 0; n < 200; n++) begin
      a = $urandom_range(0, 3) * N + idx_pool[$urandom_range(0, 3)];
      if ($urandom_range(0, 2) == 0)
        do_write(a, $urandom, $urandom_range(0, 4), 1'($urandom_range(0, 1)));
      else
        do_read(a, $urandom, $urandom_range(0, 4), 1'($urandom_range(0, 1)));
    end

    step("final", ref_douta, ref_hit(32'(addra)), 1'b0, 1'b0);
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clka);
    #1;
    if (sb.size() != 0) begin
      n_assert++; n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/direct_mapped_cache_n_words.md
Name: direct_mapped_cache_n_words

Overview:
- Direct-mapped, write-through, write-allocate cache holding N_WORDS data words, one word per line.
- Sits between the CPU pipeline and main RAM.
- Writes go into the cache line and are pushed to RAM through a flush/flush_ack handshake.
- Read misses request the word from RAM through a fetch/fetch_ack handshake, and the returned word arrives on dina.

Parameters:
- N_WORDS, 1024, number of lines; must be a power of two.
- ADDR_WIDTH, 12, width of addra; must be greater than log2(N_WORDS).
- DATA_WIDTH, 32, word width.

Ports:
- clka  input  1  clock; all state changes on the rising edge.
- rsta  input  1  asynchronous, active-high reset.
- wea  input  1  write enable; sampled in IDLE only.
- addra  input  ADDR_WIDTH  word address.
- dina  input  DATA_WIDTH  write data from the CPU, or fill data from RAM while fetch_ack is high.
- fetch_ack  input  1  RAM has placed the requested word on dina.
- flush_ack  input  1  RAM has accepted the write-through.
- douta  output  DATA_WIDTH  read data (registered).
- flush  output  1  write-through pending to RAM (registered).
- fetch  output  1  miss fill requested from RAM (registered).
- hit  output  1  current address hits a valid line (combinational).

Behaviour:
- Address split:
  - index = addra[log2(N_WORDS)-1:0].
  - tag = addra[ADDR_WIDTH-1:log2(N_WORDS)]; 2 bits at the defaults.
- Storage:
  - data array of N_WORDS x DATA_WIDTH, no reset.
  - tag array, no reset.
  - valid bit per line.
- Reset (rsta high, asynchronous):
  - all valid bits are cleared.
  - state = IDLE; douta = 0; flush = 0; fetch = 0.
  - Reset asserted mid-FLUSH or mid-FETCH abandons the transaction; no line is written.
- hit = (state==IDLE) && valid[index] && tag_array[index]==tag; 0 in every other state.
- The FSM has three states: IDLE, FLUSH and FETCH. On each clka rising edge in IDLE:
  - If wea=1 (write, takes precedence over miss detection):
    - data[index] <= dina; tag[index] <= tag; valid[index] <= 1.
    - douta <= dina.
    - flush <= 1; go to FLUSH.
    - Any previous occupant of the line is overwritten without writeback, since RAM is always current.
  - Else if hit: douta <= data[index]; one-cycle read latency.
  - Else (miss):
    - latch index and tag into fill registers.
    - fetch <= 1; go to FETCH.
    - douta holds its previous value.
- FLUSH state:
  - flush stays 1 until flush_ack is sampled high; then flush <= 0 and go to IDLE.
  - wea and fetch_ack are ignored.
- FETCH state:
  - fetch stays 1 until fetch_ack is sampled high. On that edge:
    - data[fill index] <= dina; tag <= fill tag; valid <= 1.
    - douta <= dina.
    - fetch <= 0; go to IDLE.
  - wea and flush_ack are ignored.
  - Changes of addra during FETCH do not affect which line is filled.
- flush_ack or fetch_ack arriving in IDLE is ignored.
- flush and fetch are never high together.
- After returning to IDLE, the next edge performs a normal lookup, so a stable addra yields hit=1 and douta is refreshed.
- Aliasing: addresses differing only in tag map to the same line; the newest write or fill evicts the older one.

Test Plan:
1. Reset, then write addr 0, dina 2123000123, wea for one cycle.
   - Required: flush=1 from the next edge until flush_ack is pulsed (after 10 cycles), then flush=0.
   - Required: with addra=0 held, hit=1 and douta=2123000123.
2. Read addr 1000 (cold miss).
   - Required: fetch=1 within 1 cycle and held.
   - Pulse fetch_ack with dina=1002003009. Required: fetch=0 next cycle, douta=1002003009, hit=1 afterwards.
3. Read addr 0.
   - Required: hit=1, and within 2 edges douta=2123000123 with no fetch.
4. Write addr 1024, dina 998, completing the flush handshake.
   - Required: douta=998 and hit=1 at addr 1024.
   - Then read addr 0. Required: hit=0 and fetch=1 within 2 edges, since the line was evicted by the tag mismatch.
5. Assert rsta during FETCH.
   - Required: fetch=0, douta=0 and IDLE immediately, without waiting for a clock edge.
   - Required: a read of addr 1000 then misses, because all lines are invalidated.
6. With the block in FLUSH, pulse fetch_ack and wea.
   - Required: no state, line or douta change; only flush_ack ends FLUSH.
